ahb_slave_if: RTL

AHB-side front end of the AHB-to-APB bridge, sitting directly upstream of the bridge state machine. It qualifies AHB transfers into a single-cycle `valid` and decodes the address into a one-hot APB slave select. It also pipelines address, data and direction into the two-deep registers the state machine consumes (`Haddr1/2`, `Hwdata1/2`, `Hwritereg`). Out-of-map accesses get the two-cycle AHB ERROR response and are never forwarded to the APB side.

---
 rtl/ahb_apb_pkg.sv | 50 +++++
 rtl/ahb_addr_decode.sv | 20 ++
 rtl/ahb_slave_if.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: bus encodings, slave address map,
// the AHB-side error response states and the bridge state machine encodings.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int NUM_SLAVES = 3;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_ERR1 = 2'd1,
    ERR_ERR2 = 2'd2
  } err_st_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } bridge_st_e;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are never active.
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address decode into a one-hot APB slave select and an
// in-map flag; shared by the slave interface datapath and its assertions.
module ahb_addr_decode
  import ahb_apb_pkg::*;
(
  input  logic [31:0] haddr_i,
  output logic [2:0]  tempselx_o,
  output logic        in_map_o
);

  always_comb begin
    tempselx_o    = '0;
    tempselx_o[0] = addr_in_range(haddr_i, SLV0_BASE, SLV0_LIMIT);
    tempselx_o[1] = addr_in_range(haddr_i, SLV1_BASE, SLV1_LIMIT);
    tempselx_o[2] = addr_in_range(haddr_i, SLV2_BASE, SLV2_LIMIT);
  end

  assign in_map_o = |tempselx_o;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: qualifies transfers, decodes the slave,
// pipelines address/data/direction and issues the two-cycle ERROR for unmapped addresses.
//
// state    | meaning
// ERR_OK   | normal operation, OKAY response, transfers may be qualified
// ERR_ERR1 | first ERROR cycle, master stalled (Hready_mask = 0)
// ERR_ERR2 | second ERROR cycle, ERROR completes (Hready_mask = 1)
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Hwrite,
  input  logic                 Hreadyin,
  input  logic [1:0]           Htrans,
  input  logic [31:0]          Haddr,
  input  logic [31:0]          Hwdata,
  output logic                 valid,
  output logic [2:0]           tempselx,
  output logic [31:0]          Haddr1,
  output logic [31:0]          Haddr2,
  output logic [31:0]          Hwdata1,
  output logic [31:0]          Hwdata2,
  output logic                 Hwritereg,
  output logic [1:0]           Hresp,
  output logic                 Hready_mask,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic        in_map;
  logic        active;
  logic        err_start;

  err_st_e               err_st_q;
  logic [1:0]            hresp_q;
  logic                  hready_mask_q;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic [31:0] haddr1_q,  haddr1_d;
  logic [31:0] haddr2_q,  haddr2_d;
  logic [31:0] hwdata1_q, hwdata1_d;
  logic [31:0] hwdata2_q, hwdata2_d;
  logic        hwrite_q,  hwrite_d;

  ahb_addr_decode u_decode (
    .haddr_i    (Haddr),
    .tempselx_o (tempselx),
    .in_map_o   (in_map)
  );

  assign active    = trans_active(Htrans);
  assign err_start = Hreadyin & active & ~in_map & (err_st_q == ERR_OK);
  assign valid     = rst & Hreadyin & active & in_map & (err_st_q == ERR_OK);

  always_comb begin
    haddr1_d  = haddr1_q;
    haddr2_d  = haddr2_q;
    hwdata1_d = hwdata1_q;
    hwdata2_d = hwdata2_q;
    hwrite_d  = hwrite_q;
    if (Hreadyin) begin
      haddr1_d  = Haddr;
      haddr2_d  = haddr1_q;
      hwdata1_d = Hwdata;
      hwdata2_d = hwdata1_q;
      hwrite_d  = Hwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else begin
      haddr1_q  <= haddr1_d;
      haddr2_q  <= haddr2_d;
      hwdata1_q <= hwdata1_d;
      hwdata2_q <= hwdata2_d;
      hwrite_q  <= hwrite_d;
    end
  end

  // Saturates at all-ones so a long error storm never wraps back to a small count.
  always_comb begin
    err_count_d = err_count_q;
    if (err_start && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_st_q      <= ERR_OK;
      hresp_q       <= HRESP_OKAY;
      hready_mask_q <= 1'b1;
      err_count_q   <= '0;
    end else begin
      err_count_q <= err_count_d;
      case (err_st_q)
        ERR_OK: begin
          if (err_start) begin
            err_st_q      <= ERR_ERR1;
            hresp_q       <= HRESP_ERROR;
            hready_mask_q <= 1'b0;
          end else begin
            hresp_q       <= HRESP_OKAY;
            hready_mask_q <= 1'b1;
          end
        end
        ERR_ERR1: begin
          err_st_q      <= ERR_ERR2;
          hresp_q       <= HRESP_ERROR;
          hready_mask_q <= 1'b1;
        end
        ERR_ERR2: begin
          err_st_q      <= ERR_OK;
          hresp_q       <= HRESP_OKAY;
          hready_mask_q <= 1'b1;
        end
        default: begin
          err_st_q      <= ERR_OK;
          hresp_q       <= HRESP_OKAY;
          hready_mask_q <= 1'b1;
        end
      endcase
    end
  end

  assign Haddr1      = haddr1_q;
  assign Haddr2      = haddr2_q;
  assign Hwdata1     = hwdata1_q;
  assign Hwdata2     = hwdata2_q;
  assign Hwritereg   = hwrite_q;
  assign Hresp       = hresp_q;
  assign Hready_mask = hready_mask_q;
  assign err_count   = err_count_q;

  // A qualified transfer must land in Haddr1 as an in-map address on the next edge.
  logic [2:0] chk_sel;
  logic       chk_in_map;

  ahb_addr_decode u_chk_decode (
    .haddr_i    (haddr1_q),
    .tempselx_o (chk_sel),
    .in_map_o   (chk_in_map)
  );

  a_valid_onehot: assert property (@(posedge clk) valid |-> $onehot(tempselx));
  a_err_no_valid: assert property (@(posedge clk) (err_st_q != ERR_OK) |-> !valid);
  a_pipe_in_map:  assert property (@(posedge clk) valid |=> (chk_in_map && $onehot(chk_sel)));

endmodule
